// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB latch, result select, 8x16 register file with
// same-cycle bypass read ports, forwarding tap, HALT retirement and
// retired-instruction counter.
module wb_stage #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              memValid,
    input  logic [DATA_W-1:0] readData,
    input  logic [DATA_W-1:0] aluOut,
    input  logic [DATA_W-1:0] pcInc,
    input  logic              memToReg,
    input  logic              linkSel,
    input  logic              regWrite,
    input  logic [REG_AW-1:0] writeReg,
    input  logic              haltIn,
    input  logic [REG_AW-1:0] rdAddr1,
    input  logic [REG_AW-1:0] rdAddr2,
    output logic [DATA_W-1:0] rdData1,
    output logic [DATA_W-1:0] rdData2,
    output logic              fwdValid,
    output logic [REG_AW-1:0] fwdReg,
    output logic [DATA_W-1:0] fwdData,
    output logic              createdump,
    output logic              halted,
    output logic [15:0]       retireCnt
);

    logic              wb_valid;
    logic [DATA_W-1:0] wb_read_data;
    logic [DATA_W-1:0] wb_alu_out;
    logic [DATA_W-1:0] wb_pc_inc;
    logic              wb_mem_to_reg;
    logic              wb_link_sel;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_write_reg;
    logic              wb_halt;

    logic [DATA_W-1:0] rf [NREG];
    logic [DATA_W-1:0] result;
    logic              commit;
    logic              ret;

    // MEM/WB pipeline latch: flush beats stall; flushed data fields simply hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid      <= 1'b0;
            wb_read_data  <= '0;
            wb_alu_out    <= '0;
            wb_pc_inc     <= '0;
            wb_mem_to_reg <= 1'b0;
            wb_link_sel   <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_write_reg  <= '0;
            wb_halt       <= 1'b0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (!stall) begin
            wb_valid      <= memValid;
            wb_read_data  <= readData;
            wb_alu_out    <= aluOut;
            wb_pc_inc     <= pcInc;
            wb_mem_to_reg <= memToReg;
            wb_link_sel   <= linkSel;
            wb_reg_write  <= regWrite;
            wb_write_reg  <= writeReg;
            wb_halt       <= haltIn;
        end
    end

    // Result select and commit/retire qualification; a HALT never writes
    always_comb begin
        result = wb_link_sel ? wb_pc_inc : (wb_mem_to_reg ? wb_read_data : wb_alu_out);
        commit = wb_valid & wb_reg_write & ~wb_halt & ~halted;
        ret    = wb_valid & ~halted & ~stall;
    end

    // Register file write; a stalled committing instruction rewrites the same value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (commit) begin
            rf[wb_write_reg] <= result;
        end
    end

    // Read ports with write-before-read bypass from the committing WB instruction
    always_comb begin
        rdData1 = (commit && (rdAddr1 == wb_write_reg)) ? result : rf[rdAddr1];
        rdData2 = (commit && (rdAddr2 == wb_write_reg)) ? result : rf[rdAddr2];
        fwdValid = commit;
        fwdReg   = wb_write_reg;
        fwdData  = result;
    end

    // Retirement: counter, sticky halt and one-cycle dump pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retireCnt  <= '0;
            halted     <= 1'b0;
            createdump <= 1'b0;
        end else begin
            createdump <= ret & wb_halt;
            if (ret) begin
                retireCnt <= retireCnt + 16'd1;
                if (wb_halt) begin
                    halted <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        memValid;
    logic [15:0] readData;
    logic [15:0] aluOut;
    logic [15:0] pcInc;
    logic        memToReg;
    logic        linkSel;
    logic        regWrite;
    logic [2:0]  writeReg;
    logic        haltIn;
    logic [2:0]  rdAddr1;
    logic [2:0]  rdAddr2;
    logic [15:0] rdData1;
    logic [15:0] rdData2;
    logic        fwdValid;
    logic [2:0]  fwdReg;
    logic [15:0] fwdData;
    logic        createdump;
    logic        halted;
    logic [15:0] retireCnt;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .memValid(memValid), .readData(readData), .aluOut(aluOut), .pcInc(pcInc),
        .memToReg(memToReg), .linkSel(linkSel), .regWrite(regWrite),
        .writeReg(writeReg), .haltIn(haltIn),
        .rdAddr1(rdAddr1), .rdAddr2(rdAddr2), .rdData1(rdData1), .rdData2(rdData2),
        .fwdValid(fwdValid), .fwdReg(fwdReg), .fwdData(fwdData),
        .createdump(createdump), .halted(halted), .retireCnt(retireCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [15:0] rd, input logic [15:0] alu,
                         input logic [15:0] pc, input logic m2r, input logic lnk,
                         input logic rw, input logic [2:0] wr, input logic hlt);
        memValid = v;   readData = rd; aluOut = alu; pcInc = pc;
        memToReg = m2r; linkSel = lnk; regWrite = rw; writeReg = wr; haltIn = hlt;
    endtask

    task automatic idle();
        issue(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic do_reset();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
    endtask

    task automatic read_reg(input logic [2:0] a, input logic [15:0] exp, input string tag);
        rdAddr1 = a;
        rdAddr2 = a;
        #1;
        chk({tag, "_p1"}, {16'h0, rdData1}, {16'h0, exp});
        chk({tag, "_p2"}, {16'h0, rdData2}, {16'h0, exp});
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        rdAddr1 = 3'd0; rdAddr2 = 3'd0;
        idle();
        do_reset();

        // 1. reset state
        for (int i = 0; i < 8; i++) begin
            rdAddr1 = 3'(i);
            rdAddr2 = 3'(7 - i);
            #1;
            chk("rst_rd1", {16'h0, rdData1}, 32'h0);
            chk("rst_rd2", {16'h0, rdData2}, 32'h0);
        end
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_cnt", {16'h0, retireCnt}, 32'h0);
        chk("rst_fwdv", {31'h0, fwdValid}, 32'h0);
        chk("rst_dump", {31'h0, createdump}, 32'h0);

        // 2. ALU write R3, then load R5 with bypass
        issue(1'b1, 16'h0, 16'h1234, 16'h0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
        tick();
        chk("alu_fwdv", {31'h0, fwdValid}, 32'h1);
        chk("alu_fwdr", {29'h0, fwdReg}, 32'h3);
        chk("alu_fwdd", {16'h0, fwdData}, 32'h1234);
        issue(1'b1, 16'hBEEF, 16'h0040, 16'h0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0);
        tick();
        idle();
        rdAddr1 = 3'd5;
        rdAddr2 = 3'd3;
        #1;
        chk("ld_bypass", {16'h0, rdData1}, 32'hBEEF);
        chk("r3_rf", {16'h0, rdData2}, 32'h1234);
        tick();
        read_reg(3'd5, 16'hBEEF, "r5");
        read_reg(3'd3, 16'h1234, "r3");
        chk("cnt_t2", {16'h0, retireCnt}, 32'h2);

        // 3. JAL: link overrides memToReg
        issue(1'b1, 16'hBEEF, 16'h1111, 16'h0102, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0);
        tick();
        idle();
        chk("jal_fwdd", {16'h0, fwdData}, 32'h0102);
        tick();
        read_reg(3'd7, 16'h0102, "r7");
        chk("cnt_t3", {16'h0, retireCnt}, 32'h3);

        // 4. stalled write of R2, then flushed successor
        issue(1'b1, 16'h0, 16'h00AA, 16'h0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
        tick();
        stall = 1'b1;
        issue(1'b1, 16'h0, 16'h0BAD, 16'h0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
        repeat (3) tick();
        chk("stall_cnt", {16'h0, retireCnt}, 32'h3);
        chk("stall_fwdd", {16'h0, fwdData}, 32'h00AA);
        stall = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("flush_fwdv", {31'h0, fwdValid}, 32'h0);
        chk("cnt_after_stall", {16'h0, retireCnt}, 32'h4);
        tick();
        chk("cnt_after_flush", {16'h0, retireCnt}, 32'h4);
        read_reg(3'd2, 16'h00AA, "r2");

        // 5. HALT (with regWrite set) followed by a write to R1
        issue(1'b1, 16'h0, 16'h9999, 16'h0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1);
        tick();
        chk("halt_fwdv", {31'h0, fwdValid}, 32'h0);
        chk("halt_dump0", {31'h0, createdump}, 32'h0);
        issue(1'b1, 16'h0, 16'h5555, 16'h0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
        tick();
        idle();
        chk("dump_pulse", {31'h0, createdump}, 32'h1);
        chk("halted_set", {31'h0, halted}, 32'h1);
        chk("post_halt_fwdv", {31'h0, fwdValid}, 32'h0);
        tick();
        chk("dump_end", {31'h0, createdump}, 32'h0);
        chk("halted_sticky", {31'h0, halted}, 32'h1);
        chk("cnt_halt", {16'h0, retireCnt}, 32'h5);
        read_reg(3'd1, 16'h0000, "r1");
        rst = 1'b0;
        #1;
        chk("rst_clears_halt", {31'h0, halted}, 32'h0);
        chk("rst_clears_cnt", {16'h0, retireCnt}, 32'h0);
        read_reg(3'd7, 16'h0000, "r7_rst");
        @(negedge clk) rst = 1'b1;
        #1;

        // 6. counter wrap
        issue(1'b1, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        repeat (65535) tick();
        idle();
        tick();
        chk("cnt_ffff", {16'h0, retireCnt}, 32'hFFFF);
        issue(1'b1, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();
        idle();
        tick();
        chk("cnt_wrap", {16'h0, retireCnt}, 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
